// File: rtl/dma_streamer_ua.sv
// DMA burst streamer: splits one descriptor into AXI INCR burst requests
// honouring 4KB boundaries, MAX_BEATS, outstanding credits and byte strobes.
module dma_streamer_ua #(
  parameter int STREAM_TYPE     = 0,
  parameter int ADDR_WIDTH      = 32,
  parameter int DATA_WIDTH      = 512,
  parameter int BYTES_WIDTH     = 32,
  parameter int MAX_BEATS       = 256,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start_i,
  input  logic [ADDR_WIDTH-1:0]  src_addr_i,
  input  logic [ADDR_WIDTH-1:0]  dst_addr_i,
  input  logic [BYTES_WIDTH-1:0] num_bytes_i,
  input  logic                   abort_i,
  output logic                   req_valid_o,
  input  logic                   req_ready_i,
  output logic [ADDR_WIDTH-1:0]  req_addr_o,
  output logic [7:0]             req_len_o,
  output logic [2:0]             req_size_o,
  output logic [DATA_WIDTH/8-1:0] req_first_strb_o,
  output logic [DATA_WIDTH/8-1:0] req_last_strb_o,
  output logic [BYTES_WIDTH:0]   req_bytes_o,
  input  logic                   cpl_i,
  output logic                   busy_o,
  output logic                   done_o,
  output logic                   aborted_o
);

  localparam int BPB  = DATA_WIDTH / 8;
  localparam int OFFW = $clog2(BPB);
  localparam int W    = BYTES_WIDTH + 1;
  localparam logic [3:0] MAXO = 4'(MAX_OUTSTANDING);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_REQ,
    S_DRAIN
  } state_t;

  state_t state_q, state_d;

  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [W-1:0]          rem_q, rem_d;
  logic [3:0]            outst_q, outst_d;
  logic                  abort_q, abort_d;
  logic                  done_q, done_d;
  logic                  aborted_q, aborted_d;
  logic [ADDR_WIDTH-1:0] raddr_q, raddr_d;
  logic [7:0]            len_q, len_d;
  logic [2:0]            size_q, size_d;
  logic [BPB-1:0]        fstrb_q, fstrb_d;
  logic [BPB-1:0]        lstrb_q, lstrb_d;
  logic [W-1:0]          bytes_q, bytes_d;

  logic           accept;
  logic           cpl_ok;
  logic [OFFW-1:0] c_off;
  logic [W-1:0]   c_offw;
  logic [W-1:0]   c_need;
  logic [12:0]    c_to4k;
  logic [W-1:0]   c_beats;
  logic [W-1:0]   c_cap;
  logic [W-1:0]   c_bytes;
  logic [OFFW-1:0] c_e;
  logic [BPB-1:0] c_first;
  logic [BPB-1:0] c_last;
  logic [W-1:0]   rem_after;

  assign req_valid_o = (state_q == S_REQ) && (outst_q < MAXO);
  assign accept      = req_valid_o && req_ready_i;
  assign cpl_ok      = cpl_i && (outst_q != 4'd0);
  assign rem_after   = rem_q - bytes_q;

  // Burst geometry for the current address and remaining byte count.
  always_comb begin
    c_off   = addr_q[OFFW-1:0];
    c_offw  = W'(c_off);
    c_need  = (c_offw + rem_q + W'(BPB - 1)) >> OFFW;
    c_to4k  = (13'd4096 - 13'({addr_q[11:OFFW], OFFW'(0)})) >> OFFW;
    c_beats = c_need;
    if (W'(c_to4k) < c_beats) c_beats = W'(c_to4k);
    if (W'(MAX_BEATS) < c_beats) c_beats = W'(MAX_BEATS);
    c_cap   = (c_beats << OFFW) - c_offw;
    c_bytes = (c_cap < rem_q) ? c_cap : rem_q;
    c_e     = OFFW'(c_offw + c_bytes - W'(1));
    c_first = {BPB{1'b1}} << c_off;
    c_last  = {BPB{1'b1}} >> (OFFW'(BPB - 1) - c_e);
    if (c_beats == W'(1)) begin
      c_first = c_first & c_last;
      c_last  = c_first;
    end
  end

  // Next-state, credit tracking and request field capture.
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    rem_d     = rem_q;
    outst_d   = outst_q;
    abort_d   = abort_q;
    done_d    = 1'b0;
    aborted_d = 1'b0;
    raddr_d   = raddr_q;
    len_d     = len_q;
    size_d    = size_q;
    fstrb_d   = fstrb_q;
    lstrb_d   = lstrb_q;
    bytes_d   = bytes_q;
    if (state_q != S_IDLE && abort_i) abort_d = 1'b1;
    if (accept && !cpl_ok) outst_d = outst_q + 4'd1;
    else if (!accept && cpl_ok) outst_d = outst_q - 4'd1;
    unique case (state_q)
      S_IDLE: begin
        if (start_i) begin
          addr_d  = (STREAM_TYPE == 0) ? src_addr_i : dst_addr_i;
          rem_d   = W'(num_bytes_i);
          abort_d = 1'b0;
          state_d = (num_bytes_i == '0) ? S_DRAIN : S_CALC;
        end
      end
      S_CALC: begin
        raddr_d = {addr_q[ADDR_WIDTH-1:OFFW], OFFW'(0)};
        len_d   = 8'(c_beats - W'(1));
        size_d  = 3'(OFFW);
        fstrb_d = c_first;
        lstrb_d = c_last;
        bytes_d = c_bytes;
        state_d = (abort_q || abort_i) ? S_DRAIN : S_REQ;
      end
      S_REQ: begin
        if (accept) begin
          addr_d  = addr_q + ADDR_WIDTH'(bytes_q);
          rem_d   = rem_after;
          state_d = (rem_after == '0 || abort_q || abort_i)
                    ? S_DRAIN : S_CALC;
        end
      end
      S_DRAIN: begin
        if (outst_q == 4'd0) begin
          done_d    = 1'b1;
          aborted_d = abort_q || abort_i;
          abort_d   = 1'b0;
          state_d   = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      addr_q    <= '0;
      rem_q     <= '0;
      outst_q   <= '0;
      abort_q   <= 1'b0;
      done_q    <= 1'b0;
      aborted_q <= 1'b0;
      raddr_q   <= '0;
      len_q     <= '0;
      size_q    <= '0;
      fstrb_q   <= '0;
      lstrb_q   <= '0;
      bytes_q   <= '0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      rem_q     <= rem_d;
      outst_q   <= outst_d;
      abort_q   <= abort_d;
      done_q    <= done_d;
      aborted_q <= aborted_d;
      raddr_q   <= raddr_d;
      len_q     <= len_d;
      size_q    <= size_d;
      fstrb_q   <= fstrb_d;
      lstrb_q   <= lstrb_d;
      bytes_q   <= bytes_d;
    end
  end

  assign req_addr_o       = raddr_q;
  assign req_len_o        = len_q;
  assign req_size_o       = size_q;
  assign req_first_strb_o = fstrb_q;
  assign req_last_strb_o  = lstrb_q;
  assign req_bytes_o      = bytes_q;
  assign busy_o           = (state_q != S_IDLE);
  assign done_o           = done_q;
  assign aborted_o        = aborted_q;

endmodule

// File: doc/dma_streamer_ua.md
Name: dma_streamer_ua

Overview:
Parametrised successor to the DMA read/write streamer. It splits one descriptor (address, byte count) into AXI INCR burst requests of any alignment. Each request respects the 4KB boundary, MAX_BEATS and an outstanding-burst credit limit, and carries per-burst first/last-beat byte strobes. One instance serves the AR path and one the AW path, between the DMA FSM/CSRs and the AXI interface.

Parameters:
STREAM_TYPE, 0, 0 = read (uses src_addr), 1 = write (uses dst_addr)
ADDR_WIDTH, 32, AXI address width
DATA_WIDTH, 512, bus width in bits; BPB = DATA_WIDTH/8 (power of 2, 8..128)
BYTES_WIDTH, 32, descriptor byte-count width
MAX_BEATS, 256, max beats per burst (1..256)
MAX_OUTSTANDING, 4, max accepted bursts not yet completed (1..15)

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
start_i  in  1  one-cycle descriptor start; honoured only in IDLE
src_addr_i  in  ADDR_WIDTH  descriptor source address
dst_addr_i  in  ADDR_WIDTH  descriptor destination address
num_bytes_i  in  BYTES_WIDTH  bytes to move
abort_i  in  1  stop issuing new bursts
req_valid_o  out  1  burst request valid
req_ready_i  in  1  AXI I/F accepts request
req_addr_o  out  ADDR_WIDTH  burst address, aligned down to BPB
req_len_o  out  8  AXI len (beats-1)
req_size_o  out  3  log2(BPB)
req_first_strb_o  out  BPB  strobe of first beat
req_last_strb_o  out  BPB  strobe of last beat
req_bytes_o  out  BYTES_WIDTH+1  useful bytes in this burst
cpl_i  in  1  one burst completed (RLAST/BRESP seen)
busy_o  out  1  state != IDLE
done_o  out  1  one-cycle completion pulse
aborted_o  out  1  valid with done_o: descriptor ended by abort

Behaviour:
- Reset: IDLE; every output 0; internal addr/remaining/outstanding = 0.
- States: IDLE, CALC, REQ, DRAIN.
- IDLE: start_i latches addr (per STREAM_TYPE) and remaining = num_bytes_i. Next state CALC, or DRAIN if num_bytes_i == 0.
- CALC (1 cycle, registers request fields):
  - off = addr mod BPB; a = addr - off.
  - need = ceil((off + remaining)/BPB).
  - to4k = (4096 - (a mod 4096))/BPB.
  - beats = min(need, to4k, MAX_BEATS); req_len = beats-1.
  - bytes = min(beats*BPB - off, remaining).
  - first_strb = all-ones << off.
  - e = (off + bytes - 1) mod BPB; last_strb = all-ones >> (BPB-1-e).
  - beats == 1: both strobes = first & last.
  - Compute in BYTES_WIDTH+1 bits; no truncation.
  - Next state REQ.
- REQ:
  - req_valid_o asserted only while outstanding < MAX_OUTSTANDING.
  - All req_* fields stable until accepted (valid & ready).
  - On accept: addr += bytes; remaining -= bytes; outstanding++.
  - Next state: DRAIN if remaining == 0 or abort latched, else CALC.
  - Issue rate: max one burst per 2 cycles.
- abort_i in any non-IDLE state sets a sticky abort flag.
  - A request already presented in REQ completes its handshake; valid is never dropped without acceptance.
  - No further CALC after that handshake.
- cpl_i decrements outstanding. Accept and cpl in the same cycle leave the count unchanged. cpl_i with outstanding == 0 is ignored.
- DRAIN: wait outstanding == 0, then done_o = 1 for one cycle, aborted_o = abort flag, return to IDLE and clear the flag.
  - Zero-byte descriptor: done 2 cycles after start (IDLE→DRAIN→done), no req_valid.
- start_i outside IDLE is ignored.
- Address wrap past 2^ADDR_WIDTH: the 4KB rule alone limits the burst; wrap itself is not checked.
- Asynchronous reset mid-operation: immediate return to IDLE with all outputs 0, no done pulse.

Test Plan:
- Aligned, BPB=64: start addr 0x1000, 128B, ready=1 → one req: addr 0x1000, len 1, size 6, both strobes all-ones, bytes 128. After cpl, done_o=1, aborted_o=0.
- Unaligned: addr 0x1003, 100B → addr 0x1000, len 1, bytes 100, first_strb 0xFFFF_FFFF_FFFF_FFF8, last_strb 0x0000_007F_FFFF_FFFF.
- 4KB split: addr 0x0FC0, 256B → req1 0x0FC0 len 0 bytes 64; req2 0x1000 len 2 bytes 192.
- Long + credit limit: addr 0, 20000B, MAX_OUTSTANDING=2, cpl withheld → exactly 2 reqs (len 63, at 0x0 and 0x1000), then valid low.
  - Release cpl → continue: 0x2000 len 63, 0x3000 len 63, 0x4000 len 56 bytes 3616 last_strb 0x0000_0000_FFFF_FFFF.
  - done only after the 5th cpl.
- Backpressure/abort: ready=0 for 5 cycles with abort_i pulsed → fields stable, req accepted when ready=1, no further reqs, done_o with aborted_o=1 after cpl.
- Zero bytes: start with 0B → no req_valid, done_o two cycles later. Separately, rst mid-REQ → all outputs 0 on the same edge.
